// File: rtl/systolic_feeder_if.sv
// Host/array-facing bundle of the systolic A-operand feeder: tile writes, stream control,
// and the skewed per-lane operand outputs.
interface systolic_feeder_if #(
    parameter int unsigned N    = 32,
    parameter int unsigned ROWS = 4,
    parameter int unsigned K    = 4
);
    localparam int unsigned RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int unsigned CW = (K > 1) ? $clog2(K) : 1;

    logic              wr_en;
    logic [RW-1:0]     wr_row;
    logic [CW-1:0]     wr_col;
    logic [N-1:0]      wr_data;
    logic              start;
    logic              busy;
    logic              done;
    logic [ROWS*N-1:0] a_out;
    logic [ROWS-1:0]   a_vld;

    modport master (
        output wr_en, wr_row, wr_col, wr_data, start,
        input  busy, done, a_out, a_vld
    );

    modport slave (
        input  wr_en, wr_row, wr_col, wr_data, start,
        output busy, done, a_out, a_vld
    );
endinterface

// File: rtl/systolic_feeder.sv
// Buffers a ROWS x K operand tile and streams it into the array west edge with lane r skewed
// by r cycles. Define FEEDER_PINGPONG_EN for double-buffered tiles (load n+1 while n streams).
module systolic_feeder #(
    parameter int unsigned N    = 32,
    parameter int unsigned ROWS = 4,
    parameter int unsigned K    = 4
) (
    input  logic              clk,
    input  logic              clr,
    systolic_feeder_if.slave  bus
);
    localparam int unsigned RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int unsigned CW    = (K > 1) ? $clog2(K) : 1;
    localparam int unsigned TW    = $clog2(K + ROWS);
    localparam int unsigned LastT = K + ROWS - 2;
`ifdef FEEDER_PINGPONG_EN
    localparam int unsigned Banks = 2;
`else
    localparam int unsigned Banks = 1;
`endif

    typedef enum logic [1:0] {StIdle, StStream, StDone} state_e;

    state_e            state_q, state_d;
    logic [TW-1:0]     t_q, t_d;
    logic              start_acc;
    logic              wr_ok, wr_allow;
    logic              wr_bank, rd_bank;
    logic [N-1:0]      tile_q [Banks][ROWS][K];
    logic [N-1:0]      tile_d [Banks][ROWS][K];
    logic [ROWS*N-1:0] a_out_q, a_out_d;
    logic [ROWS-1:0]   a_vld_q, a_vld_d;

`ifdef FEEDER_PINGPONG_EN
    logic act_q, act_d;

    // The write bank is always the one not streaming; a start swaps them.
    assign wr_bank  = ~act_q;
    assign act_d    = act_q ^ start_acc;
    assign rd_bank  = act_d;
    assign wr_allow = 1'b1;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            act_q <= 1'b0;
        end else begin
            act_q <= act_d;
        end
    end
`else
    assign wr_bank  = 1'b0;
    assign rd_bank  = 1'b0;
    assign wr_allow = (state_q != StStream);
`endif

    always_comb begin
        state_d   = state_q;
        t_d       = t_q;
        start_acc = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d   = StStream;
                    t_d       = '0;
                    start_acc = 1'b1;
                end
            end
            StStream: begin
                if (t_q == TW'(LastT)) begin
                    state_d = StDone;
                    t_d     = '0;
                end else begin
                    t_d = t_q + 1'b1;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    assign wr_ok = bus.wr_en && wr_allow && (32'(bus.wr_row) < ROWS) && (32'(bus.wr_col) < K);

    // Outputs are computed from the post-edge tile so a write coinciding with start is seen.
    always_comb begin
        tile_d = tile_q;
        if (wr_ok) begin
            tile_d[wr_bank][bus.wr_row][bus.wr_col] = bus.wr_data;
        end
        a_out_d = '0;
        a_vld_d = '0;
        for (int r = 0; r < int'(ROWS); r++) begin
            if (state_d == StStream && int'(t_d) >= r && int'(t_d) < r + int'(K)) begin
                a_vld_d[r]       = 1'b1;
                a_out_d[r*N +: N] = tile_d[rd_bank][r][CW'(int'(t_d) - r)];
            end
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= StIdle;
            t_q     <= '0;
            a_out_q <= '0;
            a_vld_q <= '0;
            for (int b = 0; b < int'(Banks); b++) begin
                for (int r = 0; r < int'(ROWS); r++) begin
                    for (int c = 0; c < int'(K); c++) begin
                        tile_q[b][r][c] <= '0;
                    end
                end
            end
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            a_out_q <= a_out_d;
            a_vld_q <= a_vld_d;
            tile_q  <= tile_d;
        end
    end

    assign bus.busy  = (state_q == StStream);
    assign bus.done  = (state_q == StDone);
    assign bus.a_out = a_out_q;
    assign bus.a_vld = a_vld_q;
endmodule

// File: tb/tb_systolic_feeder.sv
// Randomized bench for systolic_feeder: a tile/stream-position model predicts every output each
// cycle, and a few hand-computed streams pin that model.
module tb_systolic_feeder;
    localparam int unsigned N    = 32;
    localparam int unsigned ROWS = 2;
    localparam int unsigned K    = 2;
    localparam int          L    = K + ROWS - 1;
`ifdef FEEDER_PINGPONG_EN
    localparam bit PP = 1'b1;
`else
    localparam bit PP = 1'b0;
`endif

    logic clk = 1'b0;
    logic clr;

    systolic_feeder_if #(.N(N), .ROWS(ROWS), .K(K)) bus ();

    systolic_feeder #(.N(N), .ROWS(ROWS), .K(K)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: tile banks, a snapshot of the streaming tile, and the stream position
    // (-1 idle, 0..L-1 streaming step, L done cycle).
    logic [N-1:0] mtile [2][ROWS][K];
    logic [N-1:0] snap [ROWS][K];
    int  cyc;
    int  mact, mwb;
    bit  can_wr;

    task automatic model_clear();
        for (int b = 0; b < 2; b++)
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < K; c++) mtile[b][r][c] = '0;
        cyc  = -1;
        mact = 0;
        mwb  = 1;
    endtask

    initial begin
        model_clear();
        forever begin
            @(posedge clk or posedge clr);
            if (clr) begin
                model_clear();
            end else begin
                can_wr = PP || cyc < 0 || cyc == L;
                if (bus.wr_en && can_wr && bus.wr_row < ROWS && bus.wr_col < K)
                    mtile[PP ? mwb : 0][bus.wr_row][bus.wr_col] = bus.wr_data;
                if (cyc == L) cyc = -1;
                else if (cyc >= 0) cyc++;
                else if (bus.start) begin
                    if (PP) begin
                        mact = 1 - mact;
                        mwb  = 1 - mwb;
                    end
                    for (int r = 0; r < ROWS; r++)
                        for (int c = 0; c < K; c++) snap[r][c] = mtile[PP ? mact : 0][r][c];
                    cyc = 0;
                end
            end
        end
    end

    logic [ROWS*N-1:0] ea;
    logic [ROWS-1:0]   ev;

    initial begin
        forever begin
            @(negedge clk);
            ea = '0;
            ev = '0;
            for (int r = 0; r < ROWS; r++) begin
                if (cyc >= 0 && cyc < L && cyc - r >= 0 && cyc - r < K) begin
                    ev[r]        = 1'b1;
                    ea[r*N +: N] = snap[r][cyc-r];
                end
            end
            chk("model busy", bus.busy, (cyc >= 0 && cyc < L));
            chk("model done", bus.done, (cyc == L));
            chk("model a_vld", bus.a_vld, ev);
            chk("model a_out", bus.a_out, ea);
        end
    end

    task automatic idle_in();
        bus.wr_en   = 1'b0;
        bus.wr_row  = '0;
        bus.wr_col  = '0;
        bus.wr_data = '0;
        bus.start   = 1'b0;
    endtask

    task automatic rand_in();
        bus.wr_en   = 1'($urandom_range(0, 1));
        bus.wr_row  = 1'($urandom);
        bus.wr_col  = 1'($urandom);
        bus.wr_data = $urandom;
        bus.start   = ($urandom_range(0, 5) == 0);
    endtask

    // Called at a negedge; returns at the following negedge.
    task automatic wr(input int r, input int c, input logic [N-1:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_row  = 1'(r);
        bus.wr_col  = 1'(c);
        bus.wr_data = d;
        @(negedge clk);
        bus.wr_en = 1'b0;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    int bc, dc;
    logic b_hist [1:10];
    logic d_hist [1:10];

    initial begin
        clr = 1'b1;
        rand_in();
        // Reset with random inputs
        repeat (3) begin
            @(negedge clk);
            chk("rst busy", bus.busy, 0);
            chk("rst done", bus.done, 0);
            chk("rst a_vld", bus.a_vld, 0);
            chk("rst a_out", bus.a_out, 0);
            rand_in();
        end
        idle_in();
        clr = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("post-rst busy", bus.busy, 0);
            chk("post-rst vld", bus.a_vld, 0);
        end

        // Basic 2x2 stream
        wr(0, 0, 5); wr(0, 1, 2); wr(1, 0, 20); wr(1, 1, 7);
        pulse_start();
        chk("c1 vld", bus.a_vld, 2'b01);
        chk("c1 lane0", bus.a_out[31:0], 5);
        @(negedge clk);
        chk("c2 vld", bus.a_vld, 2'b11);
        chk("c2 lane0", bus.a_out[31:0], 2);
        chk("c2 lane1", bus.a_out[63:32], 20);
        @(negedge clk);
        chk("c3 vld", bus.a_vld, 2'b10);
        chk("c3 lane1", bus.a_out[63:32], 7);
        @(negedge clk);
        chk("c4 done", bus.done, 1);
        chk("c4 busy", bus.busy, 0);
        @(negedge clk);

`ifndef FEEDER_PINGPONG_EN
        // Write during stream is ignored
        pulse_start();
        wr(0, 0, 99);
        repeat (3) @(negedge clk);
        pulse_start();
        chk("restart lane0", bus.a_out[31:0], 5);
        repeat (4) @(negedge clk);
`endif

        // start held high: one stream, DONE, one idle cycle, then a new stream
        bus.start = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            b_hist[i] = bus.busy;
            d_hist[i] = bus.done;
        end
        bus.start = 1'b0;
        bc = 0;
        dc = 0;
        for (int i = 1; i <= 5; i++) begin
            bc += int'(b_hist[i]);
            dc += int'(d_hist[i]);
        end
        chk("held busy cycles", bc, 3);
        chk("held done count", dc, 1);
        chk("held done at c4", d_hist[4], 1);
        chk("held idle at c5", b_hist[5], 0);
        chk("held restart c6", b_hist[6], 1);
        repeat (2) @(negedge clk);

        // clr mid-stream
        wr(0, 0, 11); wr(0, 1, 12); wr(1, 0, 13); wr(1, 1, 14);
        pulse_start();
        @(negedge clk);
        #2 clr = 1'b1;
        #1;
        chk("abort busy", bus.busy, 0);
        chk("abort vld", bus.a_vld, 0);
        chk("abort a_out", bus.a_out, 0);
        @(negedge clk);
        clr = 1'b0;
        dc = 0;
        repeat (4) begin
            @(negedge clk);
            dc += int'(bus.done);
        end
        chk("abort no done", dc, 0);
        wr(0, 0, 31); wr(0, 1, 32); wr(1, 0, 33); wr(1, 1, 34);
        pulse_start();
        chk("reload lane0", bus.a_out[31:0], 31);
        @(negedge clk);
        chk("reload lane1", bus.a_out[63:32], 33);
        repeat (3) @(negedge clk);

        // Random traffic with rare resets
        for (int i = 0; i < 400; i++) begin
            rand_in();
            if ($urandom_range(0, 79) == 0) clr = 1'b1;
            @(negedge clk);
            clr = 1'b0;
        end
        idle_in();
        repeat (4) @(negedge clk);

`ifdef FEEDER_PINGPONG_EN
        // Load tile B while tile A streams
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        wr(0, 0, 'hA0); wr(0, 1, 'hA1); wr(1, 0, 'hA2); wr(1, 1, 'hA3);
        pulse_start();
        chk("pp A lane0", bus.a_out[31:0], 'hA0);
        wr(0, 0, 'hB0); wr(0, 1, 'hB1); wr(1, 0, 'hB2); wr(1, 1, 'hB3);
        pulse_start();
        chk("pp B lane0", bus.a_out[31:0], 'hB0);
        @(negedge clk);
        chk("pp B c2 lane0", bus.a_out[31:0], 'hB1);
        chk("pp B c2 lane1", bus.a_out[63:32], 'hB2);
        repeat (4) @(negedge clk);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
